// File: rtl/eq2_defs.sv
// Shared definitions for the eq2 match tracker: state encodings and defaults.
package eq2_defs;
  localparam int ST_W = 2;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_SEARCH = 2'd0;
  localparam state_t ST_LOCKED = 2'd1;
  localparam state_t ST_HOLD   = 2'd2;

  localparam int DEF_LOCK_RUN = 4;
  localparam int DEF_MISS_MAX = 2;
  localparam int DEF_CNT_W    = 8;
endpackage

// File: rtl/eq2_match_tracker_if.sv
// Sample/status bundle between a sample source and the match tracker.
interface eq2_match_tracker_if
  import eq2_defs::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             clear;
  logic             in_valid;
  logic [1:0]       a;
  logic [1:0]       b;
  logic             match_q;
  logic             locked;
  logic [CNT_W-1:0] run_len;
  logic [CNT_W-1:0] match_total;
  logic             lock_pulse;
  logic             unlock_pulse;

  modport master (
    output clear, in_valid, a, b,
    input  match_q, locked, run_len, match_total, lock_pulse, unlock_pulse
  );

  modport slave (
    input  clear, in_valid, a, b,
    output match_q, locked, run_len, match_total, lock_pulse, unlock_pulse
  );
endinterface

// File: rtl/eq2.sv
// 2-bit equality comparator: aeqb is high when a and b are bitwise equal.
module eq2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       aeqb
);
  assign aeqb = (a[1] ~^ b[1]) & (a[0] ~^ b[0]);
endmodule

// File: rtl/eq2_match_tracker.sv
// Registers eq2 results, counts match runs, and tracks lock/unlock with
// a mismatch tolerance while locked.
module eq2_match_tracker
  import eq2_defs::*;
#(
  parameter int LOCK_RUN = DEF_LOCK_RUN,
  parameter int MISS_MAX = DEF_MISS_MAX,
  parameter int CNT_W    = DEF_CNT_W
)(
  input  logic clk,
  input  logic reset_n,
  eq2_match_tracker_if.slave bus
);
  localparam int MW = $clog2(MISS_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             m;
  state_t           state, state_n;
  logic [MW-1:0]    miss_cnt, miss_n, miss_inc;
  logic [CNT_W:0]   run_inc;
  logic             run_hit;
  logic             lp_n, up_n;
  logic             match_q, locked, lock_pulse, unlock_pulse;
  logic [CNT_W-1:0] run_len, match_total;

  eq2 u_eq2 (.a(bus.a), .b(bus.b), .aeqb(m));

  // One extra bit so the lock threshold compare is exact even at saturation.
  assign run_inc  = {1'b0, run_len} + (CNT_W+1)'(1);
  assign run_hit  = run_inc >= (CNT_W+1)'(LOCK_RUN);
  assign miss_inc = miss_cnt + MW'(1);

  // Next-state, miss counter and event pulses.
  always_comb begin
    state_n = state;
    miss_n  = miss_cnt;
    lp_n    = 1'b0;
    up_n    = 1'b0;
    case (state)
      ST_SEARCH: begin
        miss_n = '0;
        if (bus.in_valid && m && run_hit) begin
          state_n = ST_LOCKED;
          lp_n    = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (bus.in_valid && !m) begin
          if (MISS_MAX == 1) begin
            state_n = ST_SEARCH;
            miss_n  = '0;
            up_n    = 1'b1;
          end else begin
            state_n = ST_HOLD;
            miss_n  = MW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (bus.in_valid) begin
          if (m) begin
            state_n = ST_LOCKED;
            miss_n  = '0;
          end else if (miss_inc == MW'(MISS_MAX)) begin
            state_n = ST_SEARCH;
            miss_n  = '0;
            up_n    = 1'b1;
          end else begin
            miss_n = miss_inc;
          end
        end
      end
      default: begin
        state_n = ST_SEARCH;
        miss_n  = '0;
      end
    endcase
  end

  // State, counters and registered outputs; clear beats in_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_SEARCH;
      miss_cnt     <= '0;
      match_q      <= 1'b0;
      locked       <= 1'b0;
      run_len      <= '0;
      match_total  <= '0;
      lock_pulse   <= 1'b0;
      unlock_pulse <= 1'b0;
    end else if (bus.clear) begin
      state        <= ST_SEARCH;
      miss_cnt     <= '0;
      match_q      <= 1'b0;
      locked       <= 1'b0;
      run_len      <= '0;
      match_total  <= '0;
      lock_pulse   <= 1'b0;
      unlock_pulse <= 1'b0;
    end else begin
      state        <= state_n;
      miss_cnt     <= miss_n;
      lock_pulse   <= lp_n;
      unlock_pulse <= up_n;
      locked       <= (state_n == ST_LOCKED) || (state_n == ST_HOLD);
      if (bus.in_valid) begin
        match_q <= m;
        if (!m)                    run_len <= '0;
        else if (run_len != CNT_MAX) run_len <= run_inc[CNT_W-1:0];
        if (m && (match_total != CNT_MAX))
          match_total <= match_total + CNT_W'(1);
      end
    end
  end

  assign bus.match_q      = match_q;
  assign bus.locked       = locked;
  assign bus.run_len      = run_len;
  assign bus.match_total  = match_total;
  assign bus.lock_pulse   = lock_pulse;
  assign bus.unlock_pulse = unlock_pulse;
endmodule

// File: tb/tb_eq2_match_tracker.sv
// Directed, table-driven bench for eq2_match_tracker (default and CNT_W=3).
module tb_eq2_match_tracker;
  import eq2_defs::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  eq2_match_tracker_if #(.CNT_W(DEF_CNT_W)) if1 ();
  eq2_match_tracker_if #(.CNT_W(3))         if2 ();

  eq2_match_tracker #(.LOCK_RUN(DEF_LOCK_RUN), .MISS_MAX(DEF_MISS_MAX), .CNT_W(DEF_CNT_W))
    dut (.clk(clk), .reset_n(reset_n), .bus(if1));
  eq2_match_tracker #(.LOCK_RUN(4), .MISS_MAX(2), .CNT_W(3))
    dut_sat (.clk(clk), .reset_n(reset_n), .bus(if2));

  typedef struct {
    logic       clr, vld;
    logic [1:0] a, b;
    logic       mq, lk;
    int         run, tot;
    logic       lp, up;
  } vec_t;

  vec_t tv[$];
  int n_pass = 0;
  int n_total = 0;

  function automatic vec_t mk(logic clr, logic vld, logic [1:0] a, logic [1:0] b,
                              logic mq, logic lk, int run, int tot, logic lp, logic up);
    vec_t v;
    v.clr = clr; v.vld = vld; v.a = a; v.b = b;
    v.mq = mq; v.lk = lk; v.run = run; v.tot = tot; v.lp = lp; v.up = up;
    return v;
  endfunction

  task automatic drive1(input logic clr, input logic vld, input logic [1:0] a, input logic [1:0] b);
    if1.clear = clr; if1.in_valid = vld; if1.a = a; if1.b = b;
  endtask

  task automatic cmp(input string nm, input logic [19:0] got, input logic [19:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got {mq,lk,run,tot,lp,up}=%h, expected %h", nm, got, exp);
  endtask

  task automatic check1(input string nm, input logic mq, input logic lk, input int run,
                        input int tot, input logic lp, input logic up);
    cmp(nm, {if1.match_q, if1.locked, if1.run_len, if1.match_total, if1.lock_pulse, if1.unlock_pulse},
        {mq, lk, run[7:0], tot[7:0], lp, up});
  endtask

  task automatic check2(input string nm, input logic mq, input logic lk, input int run,
                        input int tot, input logic lp, input logic up);
    logic [7:0] r, t;
    r = {5'd0, if2.run_len};
    t = {5'd0, if2.match_total};
    cmp(nm, {if2.match_q, if2.locked, r, t, if2.lock_pulse, if2.unlock_pulse},
        {mq, lk, run[7:0], tot[7:0], lp, up});
  endtask

  initial begin
    drive1(0, 0, 2'd0, 2'd0);
    if2.clear = 0; if2.in_valid = 0; if2.a = 0; if2.b = 0;

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check1("reset_hold", 0, 0, 0, 0, 0, 0);
    end
    reset_n = 1'b1;

    // idle after release
    for (int i = 0; i < 5; i++) tv.push_back(mk(0,0,0,0, 0,0,0,0,0,0));
    // lock acquisition
    tv.push_back(mk(0,1,0,0, 1,0,1,1,0,0));
    tv.push_back(mk(0,1,1,1, 1,0,2,2,0,0));
    tv.push_back(mk(0,1,2,2, 1,0,3,3,0,0));
    tv.push_back(mk(0,1,3,3, 1,1,4,4,1,0));
    tv.push_back(mk(0,0,0,0, 1,1,4,4,0,0));
    // lock loss via HOLD
    tv.push_back(mk(0,1,1,0, 0,1,0,4,0,0));
    tv.push_back(mk(0,1,2,0, 0,0,0,4,0,1));
    tv.push_back(mk(0,0,0,0, 0,0,0,4,0,0));
    // relock needs fresh run, then HOLD recovery
    tv.push_back(mk(0,1,3,3, 1,0,1,5,0,0));
    tv.push_back(mk(0,1,2,2, 1,0,2,6,0,0));
    tv.push_back(mk(0,1,1,1, 1,0,3,7,0,0));
    tv.push_back(mk(0,1,0,0, 1,1,4,8,1,0));
    tv.push_back(mk(0,1,1,3, 0,1,0,8,0,0));
    tv.push_back(mk(0,1,2,2, 1,1,1,9,0,0));
    // a single miss after recovery must only re-enter HOLD
    tv.push_back(mk(0,1,1,0, 0,1,0,9,0,0));
    tv.push_back(mk(0,1,2,2, 1,1,1,10,0,0));
    // clear with a valid match while locked: no pulse
    tv.push_back(mk(1,1,3,3, 0,0,0,0,0,0));
    // mismatch in SEARCH
    tv.push_back(mk(0,1,1,2, 0,0,0,0,0,0));
    // matches with gaps
    tv.push_back(mk(0,1,1,1, 1,0,1,1,0,0));
    tv.push_back(mk(0,0,0,0, 1,0,1,1,0,0));
    tv.push_back(mk(0,1,2,2, 1,0,2,2,0,0));
    tv.push_back(mk(0,0,0,3, 1,0,2,2,0,0));
    tv.push_back(mk(0,0,0,0, 1,0,2,2,0,0));
    tv.push_back(mk(0,1,3,3, 1,0,3,3,0,0));
    tv.push_back(mk(0,0,1,2, 1,0,3,3,0,0));
    tv.push_back(mk(0,1,0,0, 1,1,4,4,1,0));
    tv.push_back(mk(0,0,0,0, 1,1,4,4,0,0));
    tv.push_back(mk(1,1,0,0, 0,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0, 0,0,0,0,0,0));

    foreach (tv[i]) begin
      string nm;
      drive1(tv[i].clr, tv[i].vld, tv[i].a, tv[i].b);
      @(posedge clk); #1;
      nm = $sformatf("vec%0d", i);
      check1(nm, tv[i].mq, tv[i].lk, tv[i].run, tv[i].tot, tv[i].lp, tv[i].up);
    end

    // Asynchronous reset between clock edges
    drive1(0, 1, 2'd1, 2'd1);
    @(posedge clk); #1;
    check1("pre_async_reset", 1, 0, 1, 1, 0, 0);
    drive1(0, 0, 2'd0, 2'd0);
    #2 reset_n = 1'b0;
    #1 check1("async_reset_now", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    check1("async_reset_held", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check1("post_reset_idle", 0, 0, 0, 0, 0, 0);

    // Saturation on the 3-bit counter instance
    for (int i = 1; i <= 10; i++) begin
      int er;
      if2.in_valid = 1; if2.a = 2'(i); if2.b = 2'(i);
      @(posedge clk); #1;
      er = (i > 7) ? 7 : i;
      check2($sformatf("sat%0d", i), 1, (i >= 4), er, er, (i == 4), 0);
    end
    if2.in_valid = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/eq2_match_tracker.md
Name: eq2_match_tracker

Overview:
Sequential stage directly downstream of the eq2 2-bit comparator. It presents each valid (a, b) pair to an eq2 instance and registers the aeqb result. It tracks consecutive-match runs, declares lock after LOCK_RUN consecutive matches, and drops lock after MISS_MAX consecutive mismatches. Its outputs are lock status, run/total counters and single-cycle lock/unlock event pulses.

Parameters:
LOCK_RUN, 4, consecutive valid matches required to enter lock; legal range 1..2^CNT_W-1
MISS_MAX, 2, consecutive valid mismatches while locked that drop lock; at least 1
CNT_W, 8, width of run_len and match_total

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous clear of state and counters; priority over in_valid
in_valid  in  1  a/b sample valid this cycle
a  in  2  operand 0, fed to eq2 .a
b  in  2  operand 1, fed to eq2 .b
match_q  out  1  registered aeqb of the last valid sample
locked  out  1  high in LOCKED or HOLD
run_len  out  CNT_W  current consecutive-match count, saturating
match_total  out  CNT_W  total valid matches since reset/clear, saturating
lock_pulse  out  1  one-cycle pulse on the SEARCH->LOCKED transition
unlock_pulse  out  1  one-cycle pulse on the HOLD/LOCKED->SEARCH transition

Behaviour:
- One clock, clk. Reset is asynchronous and active-low: reset_n low forces state SEARCH and all counters and outputs to 0, regardless of clk.
- Reset asserted mid-run discards the run immediately. Outputs stay 0 until the first valid sample after reset_n is released.
- Every output is registered. A sample seen on edge N is reflected in the outputs after edge N, so latency is 1 cycle.
- When in_valid=0: state, counters and match_q hold, and both pulses are 0.
- When clear=1 (sampled on the edge): state goes to SEARCH, run_len, match_total and the miss count go to 0, match_q goes to 0, and no pulse fires, even if clear arrives while locked.
- m = eq2 aeqb, i.e. (a==b). Values are unsigned; there is no sign interpretation.
- On a valid sample, match_q <= m.
- run_len: m=1 gives +1, saturating at 2^CNT_W-1. m=0 gives 0.
- match_total: m=1 gives +1, saturating at 2^CNT_W-1, and it never wraps.
- FSM states (localparam encoding): SEARCH=2'd0, LOCKED=2'd1, HOLD=2'd2. The unused code 2'd3 recovers to SEARCH.
- SEARCH transitions:
  - valid match with run_len+1 >= LOCK_RUN -> LOCKED, with lock_pulse=1 for that cycle.
  - valid mismatch -> stay in SEARCH.
- LOCKED transitions:
  - valid match -> stay.
  - valid mismatch -> miss_cnt=1. If MISS_MAX==1, go to SEARCH with unlock_pulse=1; otherwise go to HOLD.
- HOLD transitions:
  - valid match -> LOCKED, miss_cnt=0.
  - valid mismatch -> miss_cnt+1. When miss_cnt+1 == MISS_MAX, go to SEARCH with unlock_pulse=1 and miss_cnt=0.
- miss_cnt is internal, width clog2(MISS_MAX+1), and is 0 in SEARCH.
- LOCK_RUN=1: the first valid match locks.
- The run restarts after unlock, so re-lock needs LOCK_RUN fresh matches. The mismatch that caused the unlock already zeroed run_len.
- lock_pulse and unlock_pulse are never high in the same cycle, and each lasts exactly one cycle.

Decomposition:
- Shared package/header eq2_defs: state encodings (ST_SEARCH, ST_LOCKED, ST_HOLD), the state width, and default LOCK_RUN/MISS_MAX/CNT_W constants. The testbench reuses them.
- One sub-module: the existing eq2 comparator (ports a, b, aeqb), instantiated once as the match source. All sequential logic stays in eq2_match_tracker.

Test Plan:
1. Reset and idle: reset_n=0 for 3 cycles, then release with in_valid=0 for 5 cycles -> all outputs 0 throughout. Pulling reset_n low mid-cycle (no clk edge) clears outputs immediately.
2. Lock acquisition (defaults): valid pairs 00/00, 01/01, 10/10, 11/11 -> run_len 1,2,3,4. lock_pulse=1 only in the cycle after the 4th sample, then locked=1, match_total=4.
3. Lock loss: from locked, apply 01/00 -> HOLD, locked=1. Then 10/00 -> SEARCH, unlock_pulse=1 one cycle, locked=0, run_len=0, match_total unchanged.
4. HOLD recovery: from locked, apply 01/11 then 10/10 -> back to LOCKED. No pulses, locked stays 1, run_len=1.
5. Gaps and clear: matches interleaved with in_valid=0 cycles -> counters hold across the gaps and lock still occurs on the 4th valid match. Then clear=1 together with a valid match -> SEARCH, all counters 0, no pulse.
6. Saturation (CNT_W=3): 10 consecutive valid matches -> run_len and match_total stick at 7 with no wrap, and locked stays 1.
